// File: rtl/posit_wb_queue_if.sv
// Purpose : bundles the writeback queue handshake, register-file write port,
//           scoreboard alloc/query and status signals into one interface.
// Ports   : master = execution/issue side, slave = posit_wb_queue.
interface posit_wb_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    // Result input handshake
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_addr;
    logic [1:0]        in_bank;
    logic              drain_en;

    // Register file write port
    logic              rf_we;
    logic [1:0]        rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic [1:0]        rf_wrap;

    // Status
    logic [LVL_W-1:0]  level;
    logic              idle;

    // Scoreboard alloc and hazard query
    logic              alloc_valid;
    logic [1:0]        alloc_addr;
    logic [1:0]        alloc_bank;
    logic [1:0]        q_bank;
    logic [1:0]        q_ra1;
    logic [1:0]        q_ra2;
    logic              q_busy1;
    logic              q_busy2;

    modport master (
        output in_valid, in_data, in_addr, in_bank, drain_en,
        output alloc_valid, alloc_addr, alloc_bank, q_bank, q_ra1, q_ra2,
        input  in_ready, rf_we, rf_wa, rf_wd, rf_wrap, level, idle,
        input  q_busy1, q_busy2
    );

    modport slave (
        input  in_valid, in_data, in_addr, in_bank, drain_en,
        input  alloc_valid, alloc_addr, alloc_bank, q_bank, q_ra1, q_ra2,
        output in_ready, rf_we, rf_wa, rf_wd, rf_wrap, level, idle,
        output q_busy1, q_busy2
    );
endinterface

// File: rtl/posit_wb_queue.sv
// Purpose     : posit coprocessor writeback queue; FIFO of {bank,addr,data}
//               results drained one per cycle into the banked register file.
// Latency     : push at E0, popped at E1 (rf_we high E1..E2), RF commits at E2.
// Backpressure: in_ready = !full from registered state; a same-cycle pop does
//               not free a slot for a push while full.
// Ports       : clock, reset (sync, active-high), wb (posit_wb_queue_if.slave).
// Config      : define PWB_SCOREBOARD_EN to build the 16-entry busy scoreboard;
//               otherwise alloc inputs are ignored and q_busy1/q_busy2 read 0.
module posit_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic            clock,
    input  logic            reset,
    posit_wb_queue_if.slave wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [1:0]        bank;
        logic [1:0]        addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [LVL_W-1:0]  count_q, count_d;

    logic              rf_we_q, rf_we_d;
    logic [1:0]        rf_wa_q, rf_wa_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
    logic [1:0]        rf_wrap_q, rf_wrap_d;

    logic full, empty, push, pop;
    entry_t head;

    always_comb begin
        full  = (count_q == LVL_W'(DEPTH));
        empty = (count_q == '0);
        // Push is qualified by the registered full flag only, so a pop in the
        // same cycle never lets a push slip through while full.
        push  = wb.in_valid && !full;
        pop   = wb.drain_en && !empty;
        head  = mem_q[rptr_q];
    end

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        rf_we_d   = 1'b0;
        rf_wa_d   = rf_wa_q;
        rf_wd_d   = rf_wd_q;
        rf_wrap_d = rf_wrap_q;

        // Pointers are PTR_W wide, so increment wraps modulo DEPTH.
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d    = rptr_q + 1'b1;
            rf_we_d   = 1'b1;
            rf_wa_d   = head.addr;
            rf_wd_d   = head.data;
            rf_wrap_d = head.bank;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_wa_q   <= '0;
            rf_wd_q   <= '0;
            rf_wrap_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            rf_we_q   <= rf_we_d;
            rf_wa_q   <= rf_wa_d;
            rf_wd_q   <= rf_wd_d;
            rf_wrap_q <= rf_wrap_d;
        end
    end

    // Storage needs no reset: entries are only observed between the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wptr_q] <= '{bank: wb.in_bank, addr: wb.in_addr, data: wb.in_data};
        end
    end

    assign wb.in_ready = !full;
    assign wb.level    = count_q;
    assign wb.rf_we    = rf_we_q;
    assign wb.rf_wa    = rf_wa_q;
    assign wb.rf_wd    = rf_wd_q;
    assign wb.rf_wrap  = rf_wrap_q;

`ifdef PWB_SCOREBOARD_EN
    logic [15:0] busy_q, busy_d;

    // Physical index is {bank, addr} = bank*4 + addr. The clear is applied
    // first so an alloc to the same index on the same edge wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[{rf_wrap_q, rf_wa_q}] = 1'b0;
        end
        if (wb.alloc_valid) begin
            busy_d[{wb.alloc_bank, wb.alloc_addr}] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign wb.q_busy1 = busy_q[{wb.q_bank, wb.q_ra1}];
    assign wb.q_busy2 = busy_q[{wb.q_bank, wb.q_ra2}];
    assign wb.idle    = empty && !rf_we_q && (busy_q == '0);
`else
    logic sb_inputs_unused;
    assign sb_inputs_unused = ^{wb.alloc_valid, wb.alloc_addr, wb.alloc_bank,
                                wb.q_bank, wb.q_ra1, wb.q_ra2};

    assign wb.q_busy1 = 1'b0;
    assign wb.q_busy2 = 1'b0;
    assign wb.idle    = empty && !rf_we_q;
`endif

endmodule

// File: tb/tb_posit_wb_queue.sv
module tb_posit_wb_queue;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    posit_wb_queue_if #(.DEPTH(4), .DATA_W(16)) bus ();

    posit_wb_queue #(.DEPTH(4), .DATA_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .wb    (bus)
    );

    int checks = 0;
    int fails  = 0;
    logic [19:0] expq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [1:0] b, input logic [1:0] a,
                       input logic [15:0] d);
        bus.in_valid = v;
        bus.in_bank  = b;
        bus.in_addr  = a;
        bus.in_data  = d;
        if (v) expq.push_back({b, a, d});
    endtask

    // Scoreboard monitor: each register-file write must match the oldest
    // expected result.
    always @(negedge clock) begin
        if (reset === 1'b0 && bus.rf_we === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                fails++;
                $error("FAIL unexpected_write observed=%0h expected=none",
                       {bus.rf_wrap, bus.rf_wa, bus.rf_wd});
            end else begin
                logic [19:0] e;
                e = expq.pop_front();
                chk("rf_write", {12'h0, bus.rf_wrap, bus.rf_wa, bus.rf_wd}, {12'h0, e});
            end
        end
    end

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_bank     = '0;
        bus.in_addr     = '0;
        bus.in_data     = '0;
        bus.drain_en    = 1'b0;
        bus.alloc_valid = 1'b0;
        bus.alloc_addr  = '0;
        bus.alloc_bank  = '0;
        bus.q_bank      = '0;
        bus.q_ra1       = '0;
        bus.q_ra2       = '0;

        // Reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_rf_we",    bus.rf_we,    0);
        chk("rst_rf_wa",    bus.rf_wa,    0);
        chk("rst_rf_wd",    bus.rf_wd,    0);
        chk("rst_rf_wrap",  bus.rf_wrap,  0);
        chk("rst_level",    bus.level,    0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_q_busy1",  bus.q_busy1,  0);
        chk("rst_q_busy2",  bus.q_busy2,  0);
        chk("rst_idle",     bus.idle,     1);

        // Single result: push at E0, rf_we high E1..E2
        bus.drain_en = 1'b1;
        drv(1'b1, 2'd1, 2'd2, 16'h4000);
        @(negedge clock);
        drv(1'b0, 2'd0, 2'd0, 16'h0);
        chk("single_level_e0", bus.level, 1);
        chk("single_we_e0",    bus.rf_we, 0);
        @(negedge clock);
        chk("single_we",   bus.rf_we,   1);
        chk("single_wa",   bus.rf_wa,   2);
        chk("single_wrap", bus.rf_wrap, 1);
        chk("single_wd",   bus.rf_wd,   16'h4000);
        @(negedge clock);
        chk("single_we_after", bus.rf_we, 0);
        chk("single_idle",     bus.idle,  1);

        // Fill to full with draining disabled
        bus.drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 2'(i), 2'(3 - i), 16'h1000 + 16'(i));
            @(negedge clock);
        end
        drv(1'b1, 2'd2, 2'd3, 16'h1004);
        chk("full_level",    bus.level,    4);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_rf_we",    bus.rf_we,    0);
        @(negedge clock);
        chk("full_hold_level", bus.level, 4);
        chk("full_hold_we",    bus.rf_we, 0);
        bus.drain_en = 1'b1;
        @(negedge clock);
        chk("drain_we_0",    bus.rf_we,    1);
        chk("drain_ready_0", bus.in_ready, 1);
        @(negedge clock);
        bus.in_valid = 1'b0;
        chk("drain_we_1", bus.rf_we, 1);
        for (int i = 2; i < 5; i++) begin
            @(negedge clock);
            chk("drain_we_n", bus.rf_we, 1);
        end
        @(negedge clock);
        chk("drain_done_we",    bus.rf_we, 0);
        chk("drain_done_level", bus.level, 0);

        // Simultaneous push/pop at level 2 across pointer wrap
        bus.drain_en = 1'b0;
        drv(1'b1, 2'd0, 2'd1, 16'h2000);
        @(negedge clock);
        drv(1'b1, 2'd1, 2'd2, 16'h2001);
        @(negedge clock);
        chk("pp_level_pre", bus.level, 2);
        bus.drain_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drv(1'b1, 2'(k + 2), 2'(k), 16'h2002 + 16'(k));
            @(negedge clock);
            chk("pp_level", bus.level, 2);
        end
        drv(1'b0, 2'd0, 2'd0, 16'h0);
        for (int t = 0; t < 20 && bus.idle !== 1'b1; t++) @(negedge clock);
        chk("pp_idle",     bus.idle,    1);
        chk("pp_expq_len", expq.size(), 0);

`ifdef PWB_SCOREBOARD_EN
        // Scoreboard set, query and clear
        bus.alloc_valid = 1'b1;
        bus.alloc_bank  = 2'd3;
        bus.alloc_addr  = 2'd1;
        @(negedge clock);
        bus.alloc_valid = 1'b0;
        bus.q_bank = 2'd3;
        bus.q_ra1  = 2'd1;
        bus.q_ra2  = 2'd0;
        #1;
        chk("sb_busy1_set", bus.q_busy1, 1);
        chk("sb_busy2_clr", bus.q_busy2, 0);
        chk("sb_idle_busy", bus.idle,    0);
        drv(1'b1, 2'd3, 2'd1, 16'h3c00);
        @(negedge clock);
        drv(1'b0, 2'd0, 2'd0, 16'h0);
        #1;
        chk("sb_busy1_queued", bus.q_busy1, 1);
        @(negedge clock);
        chk("sb_we_cycle",     bus.rf_we,   1);
        chk("sb_busy1_we",     bus.q_busy1, 1);
        @(negedge clock);
        chk("sb_busy1_cleared", bus.q_busy1, 0);

        // Set/clear collision on index 0/0: set wins
        drv(1'b1, 2'd0, 2'd0, 16'h1111);
        @(negedge clock);
        drv(1'b0, 2'd0, 2'd0, 16'h0);
        @(negedge clock);
        chk("coll_we", bus.rf_we, 1);
        bus.alloc_valid = 1'b1;
        bus.alloc_bank  = 2'd0;
        bus.alloc_addr  = 2'd0;
        @(negedge clock);
        bus.alloc_valid = 1'b0;
        bus.q_bank = 2'd0;
        bus.q_ra1  = 2'd0;
        #1;
        chk("coll_busy", bus.q_busy1, 1);
        chk("coll_idle", bus.idle,    0);
`else
        // Without the scoreboard, alloc has no effect on queries or idle
        bus.alloc_valid = 1'b1;
        bus.alloc_bank  = 2'd3;
        bus.alloc_addr  = 2'd1;
        @(negedge clock);
        bus.alloc_valid = 1'b0;
        bus.q_bank = 2'd3;
        bus.q_ra1  = 2'd1;
        bus.q_ra2  = 2'd1;
        #1;
        chk("nosb_busy1", bus.q_busy1, 0);
        chk("nosb_busy2", bus.q_busy2, 0);
        chk("nosb_idle",  bus.idle,    1);
`endif

        // Reset mid-drain
        bus.drain_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 2'(i), 2'(i), 16'h5000 + 16'(i));
            @(negedge clock);
        end
        drv(1'b0, 2'd0, 2'd0, 16'h0);
        chk("mid_level_pre", bus.level, 3);
        reset        = 1'b1;
        bus.drain_en = 1'b1;
        expq.delete();
        @(negedge clock);
        reset = 1'b0;
        chk("mid_level",    bus.level,    0);
        chk("mid_rf_we",    bus.rf_we,    0);
        chk("mid_idle",     bus.idle,     1);
        chk("mid_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("mid_no_write", bus.rf_we, 0);
        end
        chk("end_expq_len", expq.size(), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/posit_wb_queue.md
# posit_wb_queue

Writeback stage of the posit coprocessor. It accepts 16-bit results from the posit execution units through a valid/ready handshake and buffers them in a small FIFO. It drains them one per cycle into the banked register file write port (`wa`/`wd`/`we`/`wrap`). An optional scoreboard tracks registers with writes in flight, so the issue stage can stall on read-after-write hazards.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DATA_W`, 16: result width; must match the register file word.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: rising-edge clock for all state.
- `reset` in 1: synchronous, active-high; clears all state.
- `in_valid` in 1: execution unit presents a result.
- `in_ready` out 1: queue can accept; equals `!full`.
- `in_data` in DATA_W: result value.
- `in_addr` in 2: destination register within the bank.
- `in_bank` in 2: destination bank (the `wrap` value).
- `drain_en` in 1: permits popping the head entry this cycle.
- `rf_we` out 1: register file write enable (registered).
- `rf_wa` out 2: write address (registered).
- `rf_wd` out DATA_W: write data (registered).
- `rf_wrap` out 2: write bank (registered).
- `level` out clog2(DEPTH)+1: current occupancy.
- `alloc_valid` in 1: issue stage marks a destination as pending.
- `alloc_addr` in 2: register being marked pending.
- `alloc_bank` in 2: bank of the register being marked pending.
- `q_bank` in 2: bank for hazard queries.
- `q_ra1` in 2: first register for hazard queries.
- `q_ra2` in 2: second register for hazard queries.
- `q_busy1` out 1: combinational busy flag for `{q_bank,q_ra1}`.
- `q_busy2` out 1: combinational busy flag for `{q_bank,q_ra2}`.
- `idle` out 1: queue empty, `rf_we` low, and no busy bits set.

## Operation
- Each FIFO entry holds `{bank, addr, data}`, read and write pointers wrap modulo DEPTH, and `level` counts 0..DEPTH.
- **Push** occurs on `in_valid && in_ready`. When full, `in_ready=0` and the input is held upstream. A pop in the same cycle does not open a slot for that cycle, so there is no push-through-full.
- **Pop** occurs on `!empty && drain_en`. The head is loaded into `rf_wa/rf_wd/rf_wrap` and `rf_we` is set to 1. With no pop, `rf_we` is set to 0 and the address/data registers hold their values.
- A simultaneous push and pop (not full, not empty) leaves `level` unchanged.
- Entries drain in strict FIFO order, with no merging of writes to the same register. Back-to-back writes to the same register therefore both commit, the later one last.
- Physical register index is `bank*4 + addr`, which gives 16 entries, matching the register file banking.
- **Scoreboard**: 16 busy bits.
  - `alloc_valid` sets `busy[alloc_bank*4+alloc_addr]`.
  - A cycle with `rf_we=1` clears `busy[rf_wrap*4+rf_wa]` at the closing edge.
  - If set and clear hit the same index on the same edge, set wins.
- Reset mid-operation discards all queued entries and busy bits. No partial write is emitted afterwards.

## Timing
- Reset values: `rf_we=0`, `rf_wa=0`, `rf_wd=0`, `rf_wrap=0`, `level=0`, `in_ready=1`, `q_busy1=q_busy2=0`, `idle=1`, pointers 0, busy bits 0.
- Latency into an empty queue with `drain_en=1`:
  - Push accepted at edge E0.
  - Entry popped at E1, so `rf_we=1` during E1..E2.
  - Register file commits at E2.
- Throughput is one write per cycle sustained.
- `in_ready`, `level` and `idle` derive from registered state only, never combinationally from `in_valid`.
- `q_busy*` is combinational from the busy bits and the query ports. It reflects state as of the last edge, not an `alloc_valid` in the same cycle.
- With `drain_en=0`, the queue fills to DEPTH, then `in_ready=0`. `rf_we` stays 0 while draining is disabled.

## Configuration
- `PWB_SCOREBOARD_EN` defined: the scoreboard, the alloc ports' effect, and `q_busy*` are implemented as described.
- Not defined:
  - No busy registers are built and the alloc inputs are ignored.
  - `q_busy1=q_busy2=0` constant.
  - `idle` is `empty && !rf_we`.
- The port list is identical in both builds.

## Test plan
- **Reset and single result:** reset, then push `data=16'h4000`, `addr=2`, `bank=1` at E0 with `drain_en=1`. Required: `rf_we=1`, `rf_wa=2`, `rf_wrap=1`, `rf_wd=16'h4000` during E1..E2, and `rf_we=0` after.
- **Fill to full:** `drain_en=0`, push 5 results with DEPTH=4. Required: 4 accepted, `level=4`, `in_ready=0`, 5th held. Then `drain_en=1`: 4 writes in push order on consecutive cycles, then the 5th.
- **Simultaneous push/pop and pointer wrap:** with `level=2`, continuous push and pop for 10 cycles. Required: `level` stays 2 and the data sequence is preserved across the pointer wrap.
- **Scoreboard set, query and clear (PWB_SCOREBOARD_EN):**
  - `alloc` bank 3, reg 1. Next cycle `q_bank=3`, `q_ra1=1` gives `q_busy1=1`, and `q_ra2=0` gives `q_busy2=0`.
  - Push the result for 3/1. `q_busy1` drops the cycle after the `rf_we` cycle.
- **Scoreboard set/clear collision:** alloc 0/0 on the same edge as a commit to 0/0. Required: busy for 0/0 remains 1.
- **Reset mid-drain:** `level=3`, assert `reset` for one cycle. Required: `level=0`, `rf_we=0`, `idle=1`, and no further writes.
